// File: rtl/lfsr_keystream.sv
// Parametrised LFSR keystream generator with Fibonacci/Galois feedback,
// zero-seed lock-up protection and a valid/ready word output.
module lfsr_keystream #(
  parameter int WIDTH = 16,
  parameter int OUT_BITS = 8,
  parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed,
  input  logic [WIDTH-1:0]    taps,
  input  logic                mode,
  input  logic                enable,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic [WIDTH-1:0]    state,
  output logic                lockup
);

  localparam int CNT_W = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);
  localparam logic [WIDTH-1:0] STATE_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fsm_e;

  fsm_e                fsm_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [WIDTH-1:0]    state_r;
  logic [OUT_BITS-1:0] out_data_r;
  logic                out_valid_r;
  logic                lockup_r;

  logic [WIDTH-1:0]    next_state_s;
  logic [OUT_BITS:0]   word_ext_s;
  logic [OUT_BITS-1:0] word_shift_s;

  // One LFSR step; the output bit is always the state MSB.
  function automatic logic [WIDTH-1:0] lfsr_step(
    input logic [WIDTH-1:0] s,
    input logic [WIDTH-1:0] tp,
    input logic             galois
  );
    logic [WIDTH-1:0] n;
    if (galois) begin
      n = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? tp : STATE_ZERO);
    end else begin
      n = {s[WIDTH-2:0], ^(s & tp)};
    end
    return n;
  endfunction

  // Next-state and next-word candidates for a RUN step.
  always_comb begin
    next_state_s = lfsr_step(state_r, taps, mode);
    word_ext_s   = {out_data_r, state_r[WIDTH-1]};
    word_shift_s = word_ext_s[OUT_BITS-1:0];
  end

  // Control FSM, LFSR state and output word registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_r       <= ST_RUN;
      cnt_r       <= CNT_ZERO;
      state_r     <= RESET_SEED;
      out_data_r  <= {OUT_BITS{1'b0}};
      out_valid_r <= 1'b0;
      lockup_r    <= 1'b0;
    end else if (load) begin
      // A zero seed would lock the register up, so substitute one.
      fsm_r       <= ST_RUN;
      cnt_r       <= CNT_ZERO;
      state_r     <= (seed == STATE_ZERO) ? STATE_ONE : seed;
      out_data_r  <= {OUT_BITS{1'b0}};
      out_valid_r <= 1'b0;
      lockup_r    <= (seed == STATE_ZERO);
    end else begin
      case (fsm_r)
        ST_RUN: begin
          if (enable) begin
            state_r    <= next_state_s;
            out_data_r <= word_shift_s;
            if (cnt_r == CNT_LAST) begin
              cnt_r       <= CNT_ZERO;
              fsm_r       <= ST_HOLD;
              out_valid_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_HOLD: begin
          if (out_valid_r && out_ready) begin
            fsm_r       <= ST_RUN;
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          fsm_r       <= ST_RUN;
          cnt_r       <= CNT_ZERO;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign lockup    = lockup_r;

endmodule

// File: tb/tb_lfsr_keystream.sv
// Scoreboard bench for lfsr_keystream with WIDTH=4, OUT_BITS=8, RESET_SEED=1.
module tb_lfsr_keystream;

  localparam int W = 4;
  localparam int OB = 8;

  logic          clk;
  logic          rst;
  logic          load;
  logic [W-1:0]  seed;
  logic [W-1:0]  taps;
  logic          mode;
  logic          enable;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_data;
  logic [W-1:0]  state;
  logic          lockup;

  int n_cmp = 0;
  int n_mis = 0;
  logic [OB-1:0] exp_q[$];

  lfsr_keystream #(.WIDTH(W), .OUT_BITS(OB), .RESET_SEED(4'h1)) dut (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .taps(taps), .mode(mode),
    .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .state(state), .lockup(lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference step written bit by bit from the equations.
  function automatic logic [W-1:0] m_step(input logic [W-1:0] s, input logic [W-1:0] t,
                                          input logic gal);
    logic [W-1:0] n;
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < W; i++) if (t[i] && s[i]) fb = ~fb;
    if (gal) begin
      n = {s[W-2:0], 1'b0};
      if (s[W-1]) n = n ^ t;
    end else begin
      n = {s[W-2:0], fb};
    end
    return n;
  endfunction

  task automatic wait_valid(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [W-1:0] s);
    load = 1'b1;
    seed = s;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0; load = 1'b1; seed = 4'h5;
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    n_cmp++; if (state !== 4'h1) begin n_mis++; $display("FAIL reset_state: got %h want %h", state, 4'h1); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_mis++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (lockup !== 1'b0) begin n_mis++; $display("FAIL reset_lockup: got %b want 0", lockup); end
  endtask

  task automatic test_fibonacci;
    int cyc; bit ok; logic [OB-1:0] e;
    taps = 4'b1001; mode = 1'b0; enable = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'h1E);
    exp_q.push_back(8'hB2);
    do_load(4'h1);
    n_cmp++; if (state !== 4'h1) begin n_mis++; $display("FAIL fib_load_state: got %h want 1", state); end
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_mis++; $display("FAIL fib_word1: got %h valid %b want %h", out_data, ok, e); end
    n_cmp++; if (cyc !== OB) begin n_mis++; $display("FAIL fib_latency: got %0d want %0d", cyc, OB); end
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_mis++; $display("FAIL fib_word2: got %h valid %b want %h", out_data, ok, e); end
    n_cmp++; if (cyc !== OB + 1) begin n_mis++; $display("FAIL fib_throughput: got %0d want %0d", cyc, OB + 1); end
    n_cmp++; if (state !== 4'h3) begin n_mis++; $display("FAIL fib_wrap_state: got %h want 3", state); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL fib_handshake: got %b want 0", out_valid); end
    n_cmp++; if (state !== 4'h3) begin n_mis++; $display("FAIL fib_post_state: got %h want 3", state); end
  endtask

  task automatic test_galois;
    int cyc; bit ok; logic [OB-1:0] e;
    taps = 4'b0011; mode = 1'b1; enable = 1'b1; out_ready = 1'b0;
    exp_q.push_back(8'h13);
    do_load(4'h1);
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_mis++; $display("FAIL gal_word: got %h valid %b want %h", out_data, ok, e); end
    n_cmp++; if (state !== 4'h5) begin n_mis++; $display("FAIL gal_hold_state: got %h want 5", state); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h13 || state !== 4'h5) begin
        n_mis++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%h want v=1 d=13 s=5", i, out_valid, out_data, state);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_enable_gating;
    int cyc; bit ok; logic [OB-1:0] e; logic [W-1:0] s, s3, sd;
    logic [OB-1:0] w;
    taps = 4'($urandom_range(1, 15)); mode = 1'($urandom_range(0, 1));
    sd = 4'($urandom_range(1, 15));
    s = sd; w = 8'h00;
    for (int i = 0; i < OB; i++) begin
      w = {w[OB-2:0], s[W-1]};
      s = m_step(s, taps, mode);
      if (i == 2) s3 = s;
    end
    exp_q.push_back(w);
    enable = 1'b1; out_ready = 1'b1;
    do_load(sd);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (state !== s3 || out_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL gate_freeze%0d: got s=%h v=%b want s=%h v=0", i, state, out_valid, s3);
      end
    end
    enable = 1'b1;
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_mis++; $display("FAIL gate_word: got %h valid %b want %h", out_data, ok, e); end
    n_cmp++; if (state !== s) begin n_mis++; $display("FAIL gate_state: got %h want %h", state, s); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lockup;
    int cyc; bit ok; logic [OB-1:0] e;
    taps = 4'b1001; mode = 1'b0; enable = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'h1E);
    do_load(4'h0);
    n_cmp++; if (state !== 4'h1 || lockup !== 1'b1) begin n_mis++; $display("FAIL lock_zero: got s=%h l=%b want s=1 l=1", state, lockup); end
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_mis++; $display("FAIL lock_word: got %h valid %b want %h", out_data, ok, e); end
    n_cmp++; if (lockup !== 1'b1) begin n_mis++; $display("FAIL lock_sticky: got %b want 1", lockup); end
    enable = 1'b0;
    do_load(4'h5);
    n_cmp++; if (state !== 4'h5 || lockup !== 1'b0) begin n_mis++; $display("FAIL lock_clear: got s=%h l=%b want s=5 l=0", state, lockup); end
  endtask

  task automatic test_load_midword;
    int cyc; bit ok; logic [OB-1:0] e;
    taps = 4'b1001; mode = 1'b0; enable = 1'b1; out_ready = 1'b1;
    do_load(4'h1);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h1E);
    do_load(4'h1);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || state !== 4'h1) begin
      n_mis++; $display("FAIL mid_load: got v=%b d=%h s=%h want v=0 d=00 s=1", out_valid, out_data, state);
    end
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || out_data !== e) begin n_mis++; $display("FAIL mid_word: got %h valid %b want %h", out_data, ok, e); end
    n_cmp++; if (cyc !== OB) begin n_mis++; $display("FAIL mid_latency: got %0d want %0d", cyc, OB); end
  endtask

  task automatic test_reset_hold;
    int cyc; bit ok;
    taps = 4'b1001; mode = 1'b0; enable = 1'b1; out_ready = 1'b0;
    do_load(4'h6);
    wait_valid(cyc, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL rh_reach_hold: got valid %b want 1", ok); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (out_valid !== 1'b0 || state !== 4'h1 || out_data !== 8'h00) begin
      n_mis++; $display("FAIL rh_reset: got v=%b s=%h d=%h want v=0 s=1 d=00", out_valid, state, out_data);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; seed = 4'h0; taps = 4'b1001; mode = 1'b0;
    enable = 1'b0; out_ready = 1'b0;
    test_reset();
    test_fibonacci();
    test_galois();
    test_backpressure();
    test_enable_gating();
    test_lockup();
    test_load_midword();
    test_reset_hold();
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL scoreboard_empty: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
